// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg
// Shared types and constants for the USB transmit path (packet controller,
// bit stuffer and NRZI encoder).
//   state_t              - packet controller FSM states
//   SYNC_PATTERN_DEFAULT - SYNC byte, sent LSB-first (seven 0s then a 1)
//   EOP_SE0_BITS_DEFAULT - SE0 bit times in an EOP (legal 1..4)
//   LINE_J/LINE_K/LINE_SE0 - {dp, dm} line states
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_PATTERN_DEFAULT = 8'h80;
  localparam int         EOP_SE0_BITS_DEFAULT = 2;

  // Full-speed line encoding as {dp, dm}.
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_tx_shifter.sv
// usb_tx_shifter
// 8-bit load/shift register with a 3-bit bit counter.
//   clk, srst  - clock, synchronous active-high reset
//   load       - load ld_data and restart the bit counter (wins over shift)
//   shift      - shift right by one, bump the bit counter (wraps 7 -> 0)
//   ld_data    - byte to load
//   bit0       - current bit to present (LSB)
//   byte_done  - the bit in bit0 is the eighth bit of the byte
module usb_tx_shifter (
  input  logic       clk,
  input  logic       srst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] ld_data,
  output logic       bit0,
  output logic       byte_done
);

  logic [7:0] shreg_reg;
  logic [2:0] bit_cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (load) begin
      shreg_reg   <= ld_data;
      bit_cnt_reg <= '0;
    end else if (shift) begin
      shreg_reg   <= {1'b0, shreg_reg[7:1]};
      bit_cnt_reg <= bit_cnt_reg + 3'd1;
    end
  end

  assign bit0      = shreg_reg[0];
  assign byte_done = (bit_cnt_reg == 3'd7);

endmodule

// File: rtl/usb_tx_packet_ctrl.sv
// usb_tx_packet_ctrl
// Transmit packet sequencer in front of the bit stuffer: accepts bytes over
// valid/ready, sends SYNC, serializes data LSB-first one bit per bit_tick,
// holds on stuffer stall cycles and closes each packet with SE0 bits + one J.
//   clk, RST         - clock, synchronous active-high reset
//   bit_tick         - one bit time per strobe
//   in_data/in_valid/in_last/in_ready - byte handshake (in_ready combinational)
//   stuff_stall      - stuffer inserting a stuff bit; hold the current bit
//   tx_bit, tx_en    - bit and per-bit enable strobe to the stuffer
//   tx_se0           - EOP SE0 phase (bypasses the stuffer)
//   tx_oe            - driver enable, SYNC start through the EOP J bit
//   stuff_clr        - clears the stuffer ones-count at packet start
//   busy             - not idle
//   underrun         - byte missing at a DATA byte boundary (packet aborted)
module usb_tx_packet_ctrl
  import usb_tx_pkg::*;
#(
  parameter logic [7:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT,
  parameter int         EOP_SE0_BITS = EOP_SE0_BITS_DEFAULT
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       bit_tick,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       stuff_stall,
  output logic       tx_bit,
  output logic       tx_en,
  output logic       tx_se0,
  output logic       tx_oe,
  output logic       stuff_clr,
  output logic       busy,
  output logic       underrun
);

  localparam logic [2:0] SE0_LAST = 3'(EOP_SE0_BITS - 1);

  state_t     state_reg, state_next;
  logic [7:0] hold_reg;
  logic       hold_last_reg;
  logic       last_flag_reg;
  logic [2:0] se0_cnt_reg;
  logic       j_sent_reg;

  logic tx_bit_reg, tx_en_reg, tx_se0_reg, tx_oe_reg, stuff_clr_reg, underrun_reg;

  logic       emit, boundary, data_take, handshake;
  logic       load, shift, bit0, byte_done;
  logic [7:0] ld_data;

  // A bit is presented only on a tick the stuffer is not using.
  assign emit      = ((state_reg == SYNC) || (state_reg == DATA)) && bit_tick && !stuff_stall;
  assign boundary  = emit && byte_done;
  // The only mid-packet window for taking a byte: eighth bit of a non-last byte.
  assign data_take = boundary && (state_reg == DATA) && !last_flag_reg;
  assign handshake = (state_reg == IDLE) && in_valid && in_ready;

  usb_tx_shifter u_shifter (
    .clk       (clk),
    .srst      (RST),
    .load      (load),
    .shift     (shift),
    .ld_data   (ld_data),
    .bit0      (bit0),
    .byte_done (byte_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = SYNC;
      SYNC:    if (boundary) state_next = DATA;
      DATA:    if (boundary && (last_flag_reg || !in_valid)) state_next = EOP_SE0;
      EOP_SE0: if (bit_tick && (se0_cnt_reg == SE0_LAST)) state_next = EOP_J;
      EOP_J:   if (bit_tick && j_sent_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready = !RST && ((state_reg == IDLE) || data_take);
    busy     = (state_reg != IDLE);
    load     = handshake || (boundary && (state_reg == SYNC)) || (data_take && in_valid);
    shift    = emit && !load;
    case (state_reg)
      IDLE:    ld_data = SYNC_PATTERN;
      SYNC:    ld_data = hold_reg;
      default: ld_data = in_data;
    endcase
  end

  // Registered outputs and packet bookkeeping
  always_ff @(posedge clk) begin
    if (RST) begin
      hold_reg      <= '0;
      hold_last_reg <= 1'b0;
      last_flag_reg <= 1'b0;
      se0_cnt_reg   <= '0;
      j_sent_reg    <= 1'b0;
      tx_bit_reg    <= 1'b0;
      tx_en_reg     <= 1'b0;
      tx_se0_reg    <= 1'b0;
      tx_oe_reg     <= 1'b0;
      stuff_clr_reg <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      tx_en_reg     <= emit;
      stuff_clr_reg <= handshake;
      underrun_reg  <= data_take && !in_valid;

      if (emit) tx_bit_reg <= bit0;

      if (handshake) begin
        hold_reg      <= in_data;
        hold_last_reg <= in_last;
        tx_oe_reg     <= 1'b1;
      end

      if (boundary && (state_reg == SYNC)) last_flag_reg <= hold_last_reg;
      if (data_take && in_valid)           last_flag_reg <= in_last;

      if (state_reg != EOP_SE0) begin
        se0_cnt_reg <= '0;
      end else if (bit_tick) begin
        tx_se0_reg  <= 1'b1;
        se0_cnt_reg <= se0_cnt_reg + 3'd1;
      end

      // First EOP_J tick drives J; the second ends the packet.
      if (state_reg != EOP_J) begin
        j_sent_reg <= 1'b0;
      end else if (bit_tick) begin
        if (!j_sent_reg) begin
          tx_se0_reg <= 1'b0;
          tx_bit_reg <= 1'b1;
          j_sent_reg <= 1'b1;
        end else begin
          tx_oe_reg  <= 1'b0;
          tx_bit_reg <= 1'b0;
        end
      end
    end
  end

  assign tx_bit    = tx_bit_reg;
  assign tx_en     = tx_en_reg;
  assign tx_se0    = tx_se0_reg;
  assign tx_oe     = tx_oe_reg;
  assign stuff_clr = stuff_clr_reg;
  assign underrun  = underrun_reg;

endmodule

// File: tb/tb_usb_tx_packet_ctrl.sv
// tb_usb_tx_packet_ctrl
// Scenario tasks drive packets through usb_tx_packet_ctrl and compare the
// observed bit stream and EOP/handshake activity against a reference built
// from the packet contents (SYNC + bytes LSB-first, 2 SE0 bit times, 1 J).
module tb_usb_tx_packet_ctrl;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       bit_tick = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       stuff_stall = 1'b0;
  logic       tx_bit, tx_en, tx_se0, tx_oe, stuff_clr, busy, underrun;

  int tests_run = 0;
  int tests_failed = 0;

  usb_tx_packet_ctrl dut (
    .clk         (clk),
    .RST         (RST),
    .bit_tick    (bit_tick),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .stuff_stall (stuff_stall),
    .tx_bit      (tx_bit),
    .tx_en       (tx_en),
    .tx_se0      (tx_se0),
    .tx_oe       (tx_oe),
    .stuff_clr   (stuff_clr),
    .busy        (busy),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  // ---------------- bit_tick / stuff_stall generator ----------------
  int tick_period = 4;
  int tick_div = 0;
  int tick_idx = 0;     // ticks seen while busy
  int tick_base = 0;    // snapshot at scenario start
  int stall_at = -1;    // busy-tick index (relative) to stall
  int stall_pct = 0;

  always @(negedge clk) begin
    if (tick_div >= tick_period - 1) begin
      tick_div = 0;
      bit_tick = 1'b1;
      stuff_stall = busy && (((tick_idx - tick_base) == stall_at) ||
                             (int'($urandom_range(99)) < stall_pct));
      if (busy) tick_idx++;
    end else begin
      tick_div++;
      bit_tick = 1'b0;
      stuff_stall = 1'b0;
    end
  end

  // ---------------- output monitor ----------------
  logic got_bits[$];
  int se0_cyc = 0, j_cyc = 0, clr_cnt = 0, und_cnt = 0;
  int rdy_busy = 0, rdy_stall = 0, oe_fall = 0;
  logic prev_oe = 1'b0;
  bit after_se0 = 1'b0;

  always @(negedge clk) begin
    #2;
    if (tx_en === 1'b1) got_bits.push_back(tx_bit);
    if (tx_se0 === 1'b1) begin
      se0_cyc++;
      after_se0 = 1'b1;
    end
    if (tx_oe === 1'b1 && tx_se0 === 1'b0 && tx_bit === 1'b1 && after_se0) j_cyc++;
    if (tx_oe !== 1'b1) after_se0 = 1'b0;
    if (stuff_clr === 1'b1) clr_cnt++;
    if (underrun === 1'b1) und_cnt++;
    if (busy === 1'b1 && in_ready === 1'b1) rdy_busy++;
    if (busy === 1'b1 && in_ready === 1'b1 && stuff_stall === 1'b1) rdy_stall++;
    if (prev_oe === 1'b1 && tx_oe === 1'b0) oe_fall++;
    prev_oe = tx_oe;
  end

  // ---------------- reference model ----------------
  logic [7:0] tx_q[$];
  bit         last_q[$];
  logic       exp_bits[$];
  int         hs_cnt;
  int         hs_tick[$];   // busy-tick index of each mid-packet handshake
  logic [7:0] sync_val = 8'h80;

  int s_bits, s_se0, s_j, s_clr, s_und, s_rdy, s_rdys, s_oe;

  task automatic reset_queues();
    tx_q.delete();
    last_q.delete();
    exp_bits.delete();
    hs_tick.delete();
    hs_cnt = 0;
  endtask

  task automatic new_packet();
    for (int i = 0; i < 8; i++) exp_bits.push_back(sync_val[i]);
  endtask

  task automatic add_byte(input logic [7:0] b, input bit last, input bit sent);
    tx_q.push_back(b);
    last_q.push_back(last);
    if (sent) for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
  endtask

  task automatic snap();
    s_bits = got_bits.size();
    s_se0 = se0_cyc; s_j = j_cyc; s_clr = clr_cnt; s_und = und_cnt;
    s_rdy = rdy_busy; s_rdys = rdy_stall; s_oe = oe_fall;
    tick_base = tick_idx;
  endtask

  function automatic int bit_errors();
    int e = 0;
    for (int i = 0; i < exp_bits.size(); i++)
      if (s_bits + i >= got_bits.size() || got_bits[s_bits + i] !== exp_bits[i]) e++;
    return e;
  endfunction

  // Offers tx_q in order; withholds in_valid from index stop_at on (-1: never).
  task automatic run_stream(input int stop_at);
    int idx = 0;
    int cyc = 0;
    int limit = (stop_at >= 0) ? stop_at : tx_q.size();
    forever begin
      @(negedge clk);
      if (idx >= limit && busy === 1'b0) break;
      if (idx < limit) begin
        in_valid = 1'b1;
        in_data = tx_q[idx];
        in_last = last_q[idx];
      end else begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
        in_last = 1'($urandom);
      end
      #1;
      if (in_valid && in_ready === 1'b1) begin
        hs_cnt++;
        if (busy === 1'b1) hs_tick.push_back(tick_idx - tick_base - 1);
        idx++;
      end
      cyc++;
      if (cyc > 20000) begin
        tests_run++; tests_failed++;
        $display("FAIL run_stream timeout: consumed %0d of %0d bytes, busy=%b", idx, limit, busy);
        break;
      end
    end
    in_valid = 1'b0;
    #3;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b1; in_valid = 1'b1; in_data = 8'h3C; in_last = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    tests_run++;
    if ({tx_bit, tx_en, tx_se0, tx_oe, stuff_clr, busy, underrun, in_ready} !== 8'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {tx_bit, tx_en, tx_se0, tx_oe, stuff_clr, busy, underrun, in_ready});
    end
    in_valid = 1'b0;
    RST = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single_byte();
    reset_queues(); tick_period = 4; stall_pct = 0; stall_at = -1;
    new_packet(); add_byte(8'hA5, 1'b1, 1'b1);
    snap(); run_stream(-1);
    tests_run++;
    if (got_bits.size() - s_bits != 16) begin
      tests_failed++; $display("FAIL single_count: got %0d bits want 16", got_bits.size() - s_bits);
    end
    tests_run++;
    if (bit_errors() != 0) begin
      tests_failed++; $display("FAIL single_bits: got %0d wrong bits want 0", bit_errors());
    end
    tests_run++;
    if (se0_cyc - s_se0 != 8) begin
      tests_failed++; $display("FAIL single_se0: got %0d cycles want 8", se0_cyc - s_se0);
    end
    tests_run++;
    if (j_cyc - s_j != 4) begin
      tests_failed++; $display("FAIL single_j: got %0d cycles want 4", j_cyc - s_j);
    end
    tests_run++;
    if (clr_cnt - s_clr != 1) begin
      tests_failed++; $display("FAIL single_clr: got %0d pulses want 1", clr_cnt - s_clr);
    end
    tests_run++;
    if (rdy_busy - s_rdy != 0) begin
      tests_failed++; $display("FAIL single_ready_busy: got %0d want 0", rdy_busy - s_rdy);
    end
    tests_run++;
    if (oe_fall - s_oe != 1 || und_cnt - s_und != 0) begin
      tests_failed++;
      $display("FAIL single_oe_und: got oe_fall=%0d und=%0d want 1/0", oe_fall - s_oe, und_cnt - s_und);
    end
  endtask

  task automatic test_stall_data();
    reset_queues(); tick_period = 4; stall_pct = 0; stall_at = 13;
    new_packet(); add_byte(8'hFF, 1'b0, 1'b1); add_byte(8'h01, 1'b1, 1'b1);
    snap(); run_stream(-1);
    stall_at = -1;
    tests_run++;
    if (got_bits.size() - s_bits != 24 || bit_errors() != 0) begin
      tests_failed++;
      $display("FAIL stall_bits: got %0d bits %0d wrong want 24/0", got_bits.size() - s_bits, bit_errors());
    end
    tests_run++;
    if (rdy_busy - s_rdy != 1) begin
      tests_failed++; $display("FAIL stall_ready: got %0d want 1", rdy_busy - s_rdy);
    end
    tests_run++;
    if (hs_tick.size() != 1 || hs_tick[0] != 16) begin
      tests_failed++;
      $display("FAIL stall_hs_tick: got %0d handshakes first at %0d want 1 at 16",
               hs_tick.size(), (hs_tick.size() > 0) ? hs_tick[0] : -1);
    end
  endtask

  task automatic test_underrun();
    reset_queues(); tick_period = 3; stall_pct = 0; stall_at = -1;
    new_packet(); add_byte(8'h5A, 1'b0, 1'b1); add_byte(8'hC3, 1'b1, 1'b0);
    snap(); run_stream(1);
    tests_run++;
    if (und_cnt - s_und != 1) begin
      tests_failed++; $display("FAIL underrun_pulse: got %0d want 1", und_cnt - s_und);
    end
    tests_run++;
    if (hs_cnt != 1 || got_bits.size() - s_bits != 16 || bit_errors() != 0) begin
      tests_failed++;
      $display("FAIL underrun_bits: got hs=%0d bits=%0d wrong=%0d want 1/16/0",
               hs_cnt, got_bits.size() - s_bits, bit_errors());
    end
    tests_run++;
    if (se0_cyc - s_se0 != 6 || j_cyc - s_j != 3 || oe_fall - s_oe != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL underrun_eop: got se0=%0d j=%0d oe_fall=%0d busy=%b want 6/3/1/0",
               se0_cyc - s_se0, j_cyc - s_j, oe_fall - s_oe, busy);
    end
  endtask

  task automatic test_back_to_back();
    reset_queues(); tick_period = 2; stall_pct = 0; stall_at = -1;
    new_packet(); add_byte(8'h81, 1'b0, 1'b1); add_byte(8'h7E, 1'b1, 1'b1);
    new_packet(); add_byte(8'h00, 1'b1, 1'b1);
    snap(); run_stream(-1);
    tests_run++;
    if (got_bits.size() - s_bits != 40 || bit_errors() != 0) begin
      tests_failed++;
      $display("FAIL b2b_bits: got %0d bits %0d wrong want 40/0", got_bits.size() - s_bits, bit_errors());
    end
    tests_run++;
    if (clr_cnt - s_clr != 2 || oe_fall - s_oe != 2) begin
      tests_failed++;
      $display("FAIL b2b_clr_oe: got clr=%0d oe_fall=%0d want 2/2", clr_cnt - s_clr, oe_fall - s_oe);
    end
    tests_run++;
    if (hs_cnt != 3 || rdy_busy - s_rdy != 1 || se0_cyc - s_se0 != 8) begin
      tests_failed++;
      $display("FAIL b2b_hs: got hs=%0d rdy_busy=%0d se0=%0d want 3/1/8",
               hs_cnt, rdy_busy - s_rdy, se0_cyc - s_se0);
    end
  endtask

  task automatic test_reset_mid_data();
    int cyc = 0;
    bit took = 1'b0;
    tick_period = 4; stall_pct = 0; stall_at = -1;
    snap();
    while (!took && cyc < 100) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hE7; in_last = 1'b0;
      #1;
      if (in_ready === 1'b1) took = 1'b1;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (got_bits.size() - s_bits < 12 && cyc < 500) begin
      @(negedge clk); #3;
      cyc++;
    end
    tests_run++;
    if (got_bits.size() - s_bits < 12) begin
      tests_failed++;
      $display("FAIL rst_mid_reach: got %0d bits want 12 before reset", got_bits.size() - s_bits);
    end
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk); #1;
    tests_run++;
    if ({tx_bit, tx_en, tx_se0, tx_oe, stuff_clr, busy, underrun, in_ready} !== 8'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got %b want 00000000",
               {tx_bit, tx_en, tx_se0, tx_oe, stuff_clr, busy, underrun, in_ready});
    end
    RST = 1'b0;
    reset_queues();
    new_packet(); add_byte(8'($urandom), 1'b1, 1'b1);
    snap(); run_stream(-1);
    tests_run++;
    if (got_bits.size() - s_bits != 16 || bit_errors() != 0 || clr_cnt - s_clr != 1) begin
      tests_failed++;
      $display("FAIL rst_mid_resend: got bits=%0d wrong=%0d clr=%0d want 16/0/1",
               got_bits.size() - s_bits, bit_errors(), clr_cnt - s_clr);
    end
  endtask

  task automatic test_stall_boundary();
    reset_queues(); tick_period = 3; stall_pct = 0; stall_at = 15;
    new_packet();
    add_byte(8'($urandom), 1'b0, 1'b1);
    add_byte(8'($urandom), 1'b0, 1'b1);
    add_byte(8'($urandom), 1'b1, 1'b1);
    snap(); run_stream(-1);
    stall_at = -1;
    tests_run++;
    if (got_bits.size() - s_bits != 32 || bit_errors() != 0) begin
      tests_failed++;
      $display("FAIL bstall_bits: got %0d bits %0d wrong want 32/0", got_bits.size() - s_bits, bit_errors());
    end
    tests_run++;
    if (hs_tick.size() != 2 || hs_tick[0] != 16 || hs_tick[1] != 24) begin
      tests_failed++;
      $display("FAIL bstall_hs_tick: got n=%0d t0=%0d t1=%0d want 2/16/24", hs_tick.size(),
               (hs_tick.size() > 0) ? hs_tick[0] : -1, (hs_tick.size() > 1) ? hs_tick[1] : -1);
    end
    tests_run++;
    if (rdy_stall - s_rdys != 0 || rdy_busy - s_rdy != 2) begin
      tests_failed++;
      $display("FAIL bstall_ready: got rdy_on_stall=%0d rdy_busy=%0d want 0/2",
               rdy_stall - s_rdys, rdy_busy - s_rdy);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int npk, nbytes, total;
      reset_queues();
      tick_period = $urandom_range(1, 4);
      stall_pct = 25; stall_at = -1;
      npk = $urandom_range(1, 3);
      total = 0;
      for (int p = 0; p < npk; p++) begin
        nbytes = $urandom_range(1, 4);
        new_packet();
        for (int b = 0; b < nbytes; b++) add_byte(8'($urandom), (b == nbytes - 1), 1'b1);
        total += nbytes;
      end
      snap(); run_stream(-1);
      tests_run++;
      if (got_bits.size() - s_bits != exp_bits.size() || bit_errors() != 0) begin
        tests_failed++;
        $display("FAIL rand%0d_bits: got %0d bits %0d wrong want %0d/0", it,
                 got_bits.size() - s_bits, bit_errors(), exp_bits.size());
      end
      tests_run++;
      if (hs_cnt != total || clr_cnt - s_clr != npk || oe_fall - s_oe != npk) begin
        tests_failed++;
        $display("FAIL rand%0d_pkts: got hs=%0d clr=%0d oe_fall=%0d want %0d/%0d/%0d", it,
                 hs_cnt, clr_cnt - s_clr, oe_fall - s_oe, total, npk, npk);
      end
      tests_run++;
      if (se0_cyc - s_se0 != npk * 2 * tick_period || j_cyc - s_j != npk * tick_period) begin
        tests_failed++;
        $display("FAIL rand%0d_eop: got se0=%0d j=%0d want %0d/%0d", it, se0_cyc - s_se0,
                 j_cyc - s_j, npk * 2 * tick_period, npk * tick_period);
      end
      tests_run++;
      if (und_cnt - s_und != 0 || rdy_stall - s_rdys != 0) begin
        tests_failed++;
        $display("FAIL rand%0d_misc: got und=%0d rdy_on_stall=%0d want 0/0", it,
                 und_cnt - s_und, rdy_stall - s_rdys);
      end
    end
    stall_pct = 0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_stall_data();
    test_underrun();
    test_back_to_back();
    test_reset_mid_data();
    test_stall_boundary();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
